// File: rtl/fft_pkg.sv
// Shared FFT definitions: the state codes shared with the FFT1024 core, so that
// both `state` monitors decode identically, plus the default data and address
// widths.
//   PRE    : signed width of the Re/Im samples
//   N      : transform length in bins
//   ADDR_W : buffer address width, derived from N
package fft_pkg;

  localparam int unsigned PRE    = 32;
  localparam int unsigned N      = 1024;
  localparam int unsigned ADDR_W = $clog2(N);

  typedef enum logic [3:0] {
    StInit  = 4'd0,
    StDone  = 4'd1,
    StScan  = 4'd2,
    StFlush = 4'd4
  } state_e;

endpackage

// File: rtl/mag_sq.sv
// Registered squared magnitude: mag = re*re + im*im, one cycle of latency.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   re, im       : signed PRE-bit sample
//   mag          : unsigned 2*PRE-bit |X|^2, registered
// The worst case is 2^(2*PRE-1), reached when both components are -2^(PRE-1).
// That value fits exactly in the unsigned 2*PRE-bit result, so no saturation
// is needed.
module mag_sq #(
  parameter int unsigned PRE = 32
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic signed [PRE-1:0] re,
  input  logic signed [PRE-1:0] im,
  output logic [2*PRE-1:0]      mag
);

  logic signed [2*PRE-1:0] re_x, im_x, re_sq, im_sq;
  logic [2*PRE-1:0]        mag_d;

  always_comb begin
    re_x  = {{PRE{re[PRE-1]}}, re};
    im_x  = {{PRE{im[PRE-1]}}, im};
    // Each product fits in 2*PRE signed bits, so truncating to that width is exact.
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    mag_d = $unsigned(re_sq) + $unsigned(im_sq);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mag <= '0;
    end else begin
      mag <= mag_d;
    end
  end

endmodule

// File: rtl/fft_peak_finder.sv
// Scans bins BIN_LO..BIN_HI of a finished FFT buffer and reports the bin with
// the largest |X|^2. It uses the same Start/Done/Ack handshake as FFT1024.
//   Clk, Reset_n    : clock, asynchronous active-low reset
//   Start, Ack      : start a scan (honoured in INIT), release the result (honoured in DONE)
//   rd_addr         : buffer read address
//   rd_re, rd_im    : combinational read data for rd_addr
//   peak_bin/_mag   : index and |X|^2 of the maximum (valid while Done)
//   Done, state     : handshake flag and state monitor
// Optional macro PEAK_INTERP_EN adds the peak_mag_lo/peak_mag_hi outputs, which
// give |X|^2 of the two neighbouring bins for parabolic interpolation.
// Pipeline: A = {re, im, addr} -> B = mag_sq -> compare. Ties keep the lowest bin.
module fft_peak_finder #(
  parameter int unsigned PRE    = fft_pkg::PRE,
  parameter int unsigned ADDR_W = fft_pkg::ADDR_W,
  parameter int unsigned BIN_LO = 1,
  parameter int unsigned BIN_HI = 511
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Ack,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic signed [PRE-1:0] rd_re,
  input  logic signed [PRE-1:0] rd_im,
  output logic [ADDR_W-1:0]     peak_bin,
  output logic [2*PRE-1:0]      peak_mag,
  output logic                  Done,
  output logic [3:0]            state
`ifdef PEAK_INTERP_EN
  ,
  output logic [2*PRE-1:0]      peak_mag_lo,
  output logic [2*PRE-1:0]      peak_mag_hi
`endif
);

  import fft_pkg::*;

  localparam logic [ADDR_W-1:0] BinLo = ADDR_W'(BIN_LO);
  localparam logic [ADDR_W-1:0] BinHi = ADDR_W'(BIN_HI);

  if (BIN_LO > BIN_HI) begin : g_bad_range
    $error("fft_peak_finder: BIN_LO must not exceed BIN_HI");
  end

  state_e                  state_q, state_d;
  logic                    flush_q, flush_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic signed [PRE-1:0]   a_re_q, a_im_q;
  logic [ADDR_W-1:0]       a_addr_q, b_addr_q;
  logic                    a_vld_q, b_vld_q;
  logic [2*PRE-1:0]        b_mag;
  logic [2*PRE-1:0]        best_mag_q;
  logic [ADDR_W-1:0]       best_bin_q;
  logic                    best_upd;

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    rd_addr_d = rd_addr_q;
    unique case (state_q)
      StInit: begin
        rd_addr_d = '0;
        if (Start) begin
          state_d   = StScan;
          rd_addr_d = BinLo;
        end
      end
      StScan: begin
        if (rd_addr_q == BinHi) begin
          state_d = StFlush;
          flush_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      // Two cycles: one for stage B to take the last bin, one for its compare.
      StFlush: begin
        if (flush_q) begin
          state_d = StDone;
        end else begin
          flush_d = 1'b1;
        end
      end
      StDone: begin
        if (Ack) begin
          state_d   = StInit;
          rd_addr_d = '0;
        end
      end
      default: begin
        state_d   = StInit;
        rd_addr_d = '0;
      end
    endcase
  end

  assign best_upd = b_vld_q && (b_mag > best_mag_q);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StInit;
      flush_q    <= 1'b0;
      rd_addr_q  <= '0;
      a_re_q     <= '0;
      a_im_q     <= '0;
      a_addr_q   <= '0;
      a_vld_q    <= 1'b0;
      b_addr_q   <= '0;
      b_vld_q    <= 1'b0;
      best_mag_q <= '0;
      best_bin_q <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      rd_addr_q <= rd_addr_d;
      a_re_q    <= rd_re;
      a_im_q    <= rd_im;
      a_addr_q  <= rd_addr_q;
      a_vld_q   <= (state_q == StScan);
      b_addr_q  <= a_addr_q;
      b_vld_q   <= a_vld_q;
      if (state_q == StInit) begin
        best_mag_q <= '0;
        best_bin_q <= BinLo;
      end else if (best_upd) begin
        best_mag_q <= b_mag;
        best_bin_q <= b_addr_q;
      end
    end
  end

  mag_sq #(
    .PRE (PRE)
  ) u_mag_sq (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .re      (a_re_q),
    .im      (a_im_q),
    .mag     (b_mag)
  );

`ifdef PEAK_INTERP_EN
  logic [2*PRE-1:0] prev_mag_q, lo_q, hi_q;
  logic             hi_pend_q;

  // prev_mag_q is |X|^2 of the bin just before the one now in stage B. It is 0
  // when stage B holds BIN_LO, because it is cleared in INIT.
  // hi_pend_q marks that the next compare holds the upper neighbour of the best bin.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_mag_q <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      hi_pend_q  <= 1'b0;
    end else if (state_q == StInit) begin
      prev_mag_q <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      hi_pend_q  <= 1'b0;
    end else if (b_vld_q) begin
      prev_mag_q <= b_mag;
      if (best_upd) begin
        lo_q      <= prev_mag_q;
        hi_q      <= '0;
        hi_pend_q <= 1'b1;
      end else if (hi_pend_q) begin
        hi_q      <= b_mag;
        hi_pend_q <= 1'b0;
      end
    end
  end

  assign peak_mag_lo = lo_q;
  assign peak_mag_hi = hi_q;
`endif

  assign rd_addr  = rd_addr_q;
  assign peak_bin = best_bin_q;
  assign peak_mag = best_mag_q;
  assign Done     = (state_q == StDone);
  assign state    = state_q;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder: a table of buffer contents with
// hand-computed peaks, plus sequences for reset and the handshake.
module tb_fft_peak_finder;

  localparam int PRE    = 32;
  localparam int ADDR_W = 10;
  localparam int NENT   = 11;
  localparam int NVEC   = 7;

  logic                  Clk = 1'b0;
  logic                  Reset_n = 1'b0;
  logic                  Start = 1'b0;
  logic                  Ack = 1'b0;
  logic [ADDR_W-1:0]     rd_addr;
  logic signed [PRE-1:0] rd_re, rd_im;
  logic [ADDR_W-1:0]     peak_bin;
  logic [2*PRE-1:0]      peak_mag;
  logic                  Done;
  logic [3:0]            state;
`ifdef PEAK_INTERP_EN
  logic [2*PRE-1:0]      peak_mag_lo, peak_mag_hi;
`endif

  logic signed [PRE-1:0] mem_re [1024];
  logic signed [PRE-1:0] mem_im [1024];

  assign rd_re = mem_re[rd_addr];
  assign rd_im = mem_im[rd_addr];

  always #5 Clk = ~Clk;

  fft_peak_finder dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Ack      (Ack),
    .rd_addr  (rd_addr),
    .rd_re    (rd_re),
    .rd_im    (rd_im),
    .peak_bin (peak_bin),
    .peak_mag (peak_mag),
    .Done     (Done),
`ifdef PEAK_INTERP_EN
    .peak_mag_lo (peak_mag_lo),
    .peak_mag_hi (peak_mag_hi),
`endif
    .state    (state)
  );

  typedef struct {
    int                    vec;
    int                    addr;
    logic signed [PRE-1:0] re;
    logic signed [PRE-1:0] im;
  } ent_t;

  typedef struct {
    int               exp_bin;
    logic [2*PRE-1:0] exp_mag;
    logic [2*PRE-1:0] exp_lo;
    logic [2*PRE-1:0] exp_hi;
  } vec_t;

  ent_t ents [NENT];
  vec_t vecs [NVEC];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [2*PRE-1:0] act,
                       input logic [2*PRE-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int v);
    for (int i = 0; i < 1024; i++) begin
      mem_re[i] = '0;
      mem_im[i] = '0;
    end
    for (int k = 0; k < NENT; k++) begin
      if (ents[k].vec == v) begin
        mem_re[ents[k].addr] = ents[k].re;
        mem_im[ents[k].addr] = ents[k].im;
      end
    end
  endtask

  // Called at the 1-unit offset after an edge; returns edges from E0 to Done.
  task automatic scan(output int cyc);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    cyc = 0;
    while (Done !== 1'b1 && cyc < 2000) begin
      @(posedge Clk);
      cyc++;
      #1;
    end
  endtask

  task automatic run_vec(input int v, input bit do_ack);
    int cyc;
    load(v);
    scan(cyc);
    check($sformatf("v%0d latency", v), 64'(cyc), 64'd513);
    check($sformatf("v%0d state", v), 64'(state), 64'd1);
    check($sformatf("v%0d peak_bin", v), 64'(peak_bin), 64'(vecs[v].exp_bin));
    check($sformatf("v%0d peak_mag", v), peak_mag, vecs[v].exp_mag);
    check($sformatf("v%0d rd_addr", v), 64'(rd_addr), 64'd511);
`ifdef PEAK_INTERP_EN
    check($sformatf("v%0d peak_mag_lo", v), peak_mag_lo, vecs[v].exp_lo);
    check($sformatf("v%0d peak_mag_hi", v), peak_mag_hi, vecs[v].exp_hi);
`endif
    if (do_ack) begin
      Ack = 1'b1;
      @(posedge Clk);
      #1 Ack = 1'b0;
      check($sformatf("v%0d done after ack", v), 64'(Done), 64'd0);
      check($sformatf("v%0d state after ack", v), 64'(state), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;

    ents[0]  = '{0,  37, 32'sd1000, 32'sd0};
    ents[1]  = '{1,  10, 32'sd500, 32'sd0};
    ents[2]  = '{1,  20, 32'sd0, 32'sd500};
    ents[3]  = '{2, 100, 32'sh8000_0000, 32'sh8000_0000};
    ents[4]  = '{3,   0, 32'sh4000_0000, 32'sd0};
    ents[5]  = '{3,   5, 32'sd3, 32'sd0};
    ents[6]  = '{5, 510, 32'sd2, 32'sd0};
    ents[7]  = '{5, 511, 32'sd7, -32'sd7};
    ents[8]  = '{6,  36, 32'sd300, 32'sd0};
    ents[9]  = '{6,  37, 32'sd1000, 32'sd0};
    ents[10] = '{6,  38, 32'sd400, 32'sd0};

    vecs[0] = '{37,  64'd1000000, 64'd0, 64'd0};
    vecs[1] = '{10,  64'd250000, 64'd0, 64'd0};
    vecs[2] = '{100, 64'h8000_0000_0000_0000, 64'd0, 64'd0};
    vecs[3] = '{5,   64'd9, 64'd0, 64'd0};
    vecs[4] = '{1,   64'd0, 64'd0, 64'd0};
    vecs[5] = '{511, 64'd98, 64'd4, 64'd0};
    vecs[6] = '{37,  64'd1000000, 64'd90000, 64'd160000};

    load(4);
    #1;
    check("reset state", 64'(state), 64'd0);
    check("reset Done", 64'(Done), 64'd0);
    check("reset rd_addr", 64'(rd_addr), 64'd0);
    check("reset peak_bin", 64'(peak_bin), 64'd0);
    check("reset peak_mag", peak_mag, 64'd0);
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    for (int v = 0; v < NVEC; v++) begin
      run_vec(v, 1'b1);
    end

    // Mid-scan reset; Start and Ack held high during the scan must be ignored.
    load(0);
    Start = 1'b1;
    @(posedge Clk);
    #1 Ack = 1'b1;
    repeat (50) @(posedge Clk);
    #1;
    check("mid-scan state", 64'(state), 64'd2);
    Start = 1'b0;
    Ack = 1'b0;
    Reset_n = 1'b0;
    #1;
    check("mid-reset state", 64'(state), 64'd0);
    check("mid-reset Done", 64'(Done), 64'd0);
    check("mid-reset rd_addr", 64'(rd_addr), 64'd0);
    check("mid-reset peak_bin", 64'(peak_bin), 64'd0);
    check("mid-reset peak_mag", peak_mag, 64'd0);
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge Clk);
      #1;
      if (Done === 1'b1) dones++;
    end
    check("no Done after reset", 64'(dones), 64'd0);
    check("idle after reset", 64'(state), 64'd0);
    run_vec(0, 1'b1);

    // Start together with Ack in DONE must return to INIT without a rescan.
    run_vec(1, 1'b0);
    Start = 1'b1;
    Ack = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    Ack = 1'b0;
    check("start+ack state", 64'(state), 64'd0);
    check("start+ack Done", 64'(Done), 64'd0);
    check("start+ack rd_addr", 64'(rd_addr), 64'd0);
    repeat (5) @(posedge Clk);
    #1;
    check("no rescan state", 64'(state), 64'd0);
    check("no rescan rd_addr", 64'(rd_addr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
